mem_bus_arbiter: RTL and testbench

- Shares the single main-memory port between NUM_REQ cache controllers using round-robin arbitration.
- Sits between the per-core cache controllers and main memory.
- Forwards one block transaction at a time: block read for allocate, block write for write_back/flush.
- Routes the memory response and ack back to the granted requester only.

---
 rtl/mem_bus_arbiter_if.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the shared memory port.
// slave: arbiter view; master: requesters plus memory view.
interface mem_bus_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 32,
  parameter int BLOCK_SIZE = 2
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = BLOCK_SIZE * WORD_WIDTH;

  logic [NUM_REQ-1:0]            req_cs;
  logic [NUM_REQ-1:0]            req_rw;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*BW-1:0]         req_wdata;
  logic [NUM_REQ-1:0]            req_ack;
  logic [BW-1:0]                 rsp_data;
  logic [IW-1:0]                 grant_id;
  logic                          busy;
  logic                          mem_cs;
  logic                          mem_rw;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [BW-1:0]                 mem_wdata;
  logic                          mem_ack;
  logic [BW-1:0]                 mem_rdata;

  modport slave (
    input  req_cs, req_rw, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ack, rsp_data, grant_id, busy,
    output mem_cs, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output req_cs, req_rw, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ack, rsp_data, grant_id, busy,
    input  mem_cs, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one block memory port among NUM_REQ caches.
// Define MEM_ARB_TIMEOUT_EN to add the WAIT_ACK watchdog and timeout_err.
module mem_bus_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 12,
  parameter int WORD_WIDTH     = 32,
  parameter int BLOCK_SIZE     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic timeout_err,
`endif
  mem_bus_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = ADDR_WIDTH;
  localparam int BW = BLOCK_SIZE * WORD_WIDTH;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_ACK, RESPOND, RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      grant_id_q, grant_id_d;
  logic               busy_q, busy_d;
  logic               rw_q, rw_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [BW-1:0]      wdata_q, wdata_d;
  logic               mem_cs_q, mem_cs_d;
  logic               mem_rw_q, mem_rw_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [BW-1:0]      mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]      rsp_q, rsp_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               to_q, to_d;
`endif

  logic [IW-1:0]      pick;
  logic               sel_rw;
  logic [AW-1:0]      sel_addr;
  logic [BW-1:0]      sel_wdata;
  logic [NUM_REQ-1:0] own_oh;
  logic               own_cs;
  int                 rank;
  int                 best;

  // Lowest rotated distance from ptr wins among pending requesters.
  always_comb begin
    pick      = '0;
    best      = NUM_REQ;
    rank      = 0;
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rank = i - int'(ptr_q);
      if (rank < 0) rank = rank + NUM_REQ;
      if (bus.req_cs[i] && rank < best) begin
        best = rank;
        pick = IW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == pick) begin
        sel_rw    = bus.req_rw[i];
        sel_addr  = bus.req_addr[i*AW +: AW];
        sel_wdata = bus.req_wdata[i*BW +: BW];
      end
    end
  end

  always_comb begin
    own_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      own_oh[i] = (IW'(i) == grant_id_q);
    end
    own_cs = |(bus.req_cs & own_oh);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_cs_d    = mem_cs_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_d       = rsp_q;
    ack_d       = ack_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    to_d        = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.req_cs) begin
          grant_id_d = pick;
          rw_d       = sel_rw;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          busy_d     = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        mem_cs_d    = 1'b1;
        mem_rw_d    = rw_q;
        mem_addr_d  = addr_q;
        mem_wdata_d = wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
        state_d     = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.mem_ack) begin
          if (!rw_q) rsp_d = bus.mem_rdata;
          mem_cs_d = 1'b0;
          ack_d    = own_oh;
          state_d  = RESPOND;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          mem_cs_d = 1'b0;
          ack_d    = own_oh;
          to_d     = 1'b1;
          state_d  = RESPOND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESPOND: begin
        ack_d = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        to_d  = 1'b0;
`endif
        if (grant_id_q == IW'(NUM_REQ - 1)) ptr_d = '0;
        else ptr_d = grant_id_q + 1'b1;
        state_d = RELEASE;
      end
      RELEASE: begin
        // Wait out a lingering mem_ack and the owner's req_cs.
        if (!bus.mem_ack && !own_cs) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_id_q  <= '0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_cs_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_q       <= '0;
      ack_q       <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      to_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_cs_q    <= mem_cs_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_q       <= rsp_d;
      ack_q       <= ack_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      to_q        <= to_d;
`endif
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.rsp_data  = rsp_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = busy_q;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign timeout_err   = to_q;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a delayed-ack memory responder.
// Define MEM_ARB_TIMEOUT_EN to also exercise the watchdog path.
module tb_mem_bus_arbiter;
  localparam logic [63:0] R1  = 64'hDEADBEEF_12345678;
  localparam logic [63:0] R2  = 64'h0BADF00D_CAFEBABE;
  localparam logic [63:0] R3  = 64'h11111111_22222222;
  localparam logic [63:0] WD1 = 64'hA5A5A5A5_5A5A5A5A;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ack_dly = 3;
  bit   mem_hold = 0;
  int   mcnt = 0;
  logic [63:0] rdata_v = R1;
`ifdef MEM_ARB_TIMEOUT_EN
  logic timeout_err;
`endif

  mem_bus_arbiter_if #(
    .NUM_REQ(4), .ADDR_WIDTH(12),
    .WORD_WIDTH(32), .BLOCK_SIZE(2)
  ) bus ();

  mem_bus_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(12),
    .WORD_WIDTH(32), .BLOCK_SIZE(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef MEM_ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Memory: ack a fixed number of cycles after mem_cs, one-cycle pulse.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      step();
      if (bus.mem_ack) begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        mcnt = 0;
      end else if (!bus.mem_cs || mem_hold) begin
        mcnt = 0;
      end else begin
        mcnt++;
        if (mcnt >= ack_dly) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdata_v;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic rw,
                         input logic [11:0] a,
                         input logic [63:0] wd);
    bus.req_rw[i]           = rw;
    bus.req_addr[i*12 +: 12] = a;
    bus.req_wdata[i*64 +: 64] = wd;
    bus.req_cs[i]           = 1'b1;
  endtask

  task automatic run_txn(input int id,
                         input logic [63:0] exp_rsp,
                         input string tag);
    int n;
    n = 0;
    while (bus.req_ack == '0 && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_ack"}, 64'(bus.req_ack), 64'(1) << id);
    chk({tag, "_gid"}, 64'(bus.grant_id), 64'(id));
    chk({tag, "_rsp"}, bus.rsp_data, exp_rsp);
    bus.req_cs[id] = 1'b0;
    step();
    chk({tag, "_ack0"}, 64'(bus.req_ack), 64'd0);
    step();
    chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic rst_pulse();
    bus.req_cs = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int cs1;
    rst           = 1'b1;
    bus.req_cs    = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #3;
    chk("rst_ack", 64'(bus.req_ack), 64'd0);
    chk("rst_rsp", bus.rsp_data, 64'd0);
    chk("rst_gid", 64'(bus.grant_id), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_cs", 64'(bus.mem_cs), 64'd0);
    chk("rst_rw", 64'(bus.mem_rw), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wd", bus.mem_wdata, 64'd0);
    step();
    rst = 1'b0;

    // single read by requester 2
    rdata_v = R1;
    set_req(2, 1'b0, 12'h3A4, '0);
    step();
    chk("rd_busy", 64'(bus.busy), 64'd1);
    chk("rd_cs_early", 64'(bus.mem_cs), 64'd0);
    step();
    chk("rd_cs", 64'(bus.mem_cs), 64'd1);
    chk("rd_addr", 64'(bus.mem_addr), 64'h3A4);
    chk("rd_rw", 64'(bus.mem_rw), 64'd0);
    run_txn(2, R1, "rd2");

    // ptr now 3: 3 wins over 0
    set_req(0, 1'b0, 12'h100, '0);
    set_req(3, 1'b0, 12'h300, '0);
    run_txn(3, R1, "ptr3");
    run_txn(0, R1, "ptr0");

    // all four at once after reset
    rst_pulse();
    chk("rr_rst_rsp", bus.rsp_data, 64'd0);
    rdata_v = R2;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 12'(i), '0);
    run_txn(0, R2, "rr0");
    bus.req_cs[0] = 1'b1;
    run_txn(1, R2, "rr1");
    run_txn(2, R2, "rr2");
    run_txn(3, R2, "rr3");
    run_txn(0, R2, "rr0b");

    // write by 1 while 3 waits
    rdata_v = R3;
    set_req(1, 1'b1, 12'h010, WD1);
    step();
    chk("wr_gid", 64'(bus.grant_id), 64'd1);
    step();
    chk("wr_cs", 64'(bus.mem_cs), 64'd1);
    chk("wr_rw", 64'(bus.mem_rw), 64'd1);
    chk("wr_addr", 64'(bus.mem_addr), 64'h010);
    chk("wr_wd", bus.mem_wdata, WD1);
    cs1 = cyc;
    set_req(3, 1'b0, 12'h2F0, '0);
    set_req(1, 1'b0, 12'hFFF, 64'd7);
    run_txn(1, R2, "wr1");
    n = 0;
    while (!bus.mem_cs && n < 40) begin
      step();
      n++;
    end
    chk("wr_gnt3", 64'(bus.grant_id), 64'd3);
    chk("wr_addr3", 64'(bus.mem_addr), 64'h2F0);
    chk("wr_gap", 64'((cyc - cs1) >= 5), 64'd1);
    run_txn(3, R3, "wr3");

    // requester 0 drops req_cs in WAIT_ACK
    rdata_v = R1;
    set_req(0, 1'b0, 12'h0AA, '0);
    step();
    step();
    chk("drop_cs", 64'(bus.mem_cs), 64'd1);
    bus.req_cs[0] = 1'b0;
    run_txn(0, R1, "drop0");

    // async reset during WAIT_ACK
    mem_hold = 1'b1;
    set_req(2, 1'b0, 12'h222, '0);
    step();
    step();
    chk("ar_cs_pre", 64'(bus.mem_cs), 64'd1);
    chk("ar_gid_pre", 64'(bus.grant_id), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_cs", 64'(bus.mem_cs), 64'd0);
    chk("ar_busy", 64'(bus.busy), 64'd0);
    chk("ar_gid", 64'(bus.grant_id), 64'd0);
    chk("ar_ack", 64'(bus.req_ack), 64'd0);
    bus.req_cs = '0;
    set_req(1, 1'b0, 12'h111, '0);
    set_req(3, 1'b0, 12'h333, '0);
    step();
    rst = 1'b0;
    mem_hold = 1'b0;
    rdata_v = R2;
    step();
    chk("ar_first", 64'(bus.grant_id), 64'd1);
    run_txn(1, R2, "ar1");
    run_txn(3, R2, "ar3");

`ifdef MEM_ARB_TIMEOUT_EN
    // memory never acks: watchdog completes it
    mem_hold = 1'b1;
    chk("to_err0", 64'(timeout_err), 64'd0);
    set_req(0, 1'b0, 12'h0C0, '0);
    set_req(1, 1'b0, 12'h0C1, '0);
    step();
    step();
    n = 0;
    while (bus.mem_cs && n < 50) begin
      n++;
      step();
    end
    chk("to_len", 64'(n), 64'd8);
    chk("to_ack", 64'(bus.req_ack), 64'd1);
    chk("to_err", 64'(timeout_err), 64'd1);
    chk("to_rsp", bus.rsp_data, R2);
    bus.req_cs[0] = 1'b0;
    mem_hold = 1'b0;
    rdata_v = R3;
    step();
    chk("to_err_clr", 64'(timeout_err), 64'd0);
    chk("to_ack_clr", 64'(bus.req_ack), 64'd0);
    step();
    run_txn(1, R3, "to_next");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
